sm_scoreboard_ctrl: RTL and testbench

//  SM-level issue controller for the 4-lane SP pipeline (ID->EX->MEM->WB). Tracks pending GPR/predicate

---
 rtl/sm_scoreboard_ctrl_if.sv | 43 ++++
 rtl/sm_scoreboard_ctrl.sv | 75 +++++++
 tb/tb_sm_scoreboard_ctrl.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/sm_scoreboard_ctrl_if.sv
// sm_scoreboard_ctrl_if: issue-controller bus (lane busy, ID decode, WB retire, drain in; stall/flush/hold/fire/ack/pending/count out)
interface sm_scoreboard_ctrl_if #(
  parameter int NUM_SP = 4,
  parameter int CNT_W = 16
);
  logic [NUM_SP-1:0] core_busy;
  logic id_valid;
  logic id_rf_we;
  logic [3:0] id_rD_addr;
  logic id_pred_we;
  logic [1:0] id_pred_wr_sel;
  logic [11:0] id_src_addr;
  logic [2:0] id_src_use;
  logic id_pred_use;
  logic [1:0] id_pred_rd_sel;
  logic branch_flush;
  logic wb_valid;
  logic wb_rf_we;
  logic [3:0] wb_rD_addr;
  logic wb_pred_we;
  logic [1:0] wb_pred_wr_sel;
  logic drain_req;
  logic stall;
  logic flush_id;
  logic issue_hold;
  logic issue_fire;
  logic drain_ack;
  logic [15:0] gpr_pending;
  logic [3:0] pred_pending;
  logic [CNT_W-1:0] hazard_cnt;
  modport master (
    output core_busy, id_valid, id_rf_we, id_rD_addr, id_pred_we, id_pred_wr_sel, id_src_addr,
           id_src_use, id_pred_use, id_pred_rd_sel, branch_flush, wb_valid, wb_rf_we, wb_rD_addr,
           wb_pred_we, wb_pred_wr_sel, drain_req,
    input  stall, flush_id, issue_hold, issue_fire, drain_ack, gpr_pending, pred_pending, hazard_cnt
  );
  modport slave (
    input  core_busy, id_valid, id_rf_we, id_rD_addr, id_pred_we, id_pred_wr_sel, id_src_addr,
           id_src_use, id_pred_use, id_pred_rd_sel, branch_flush, wb_valid, wb_rf_we, wb_rD_addr,
           wb_pred_we, wb_pred_wr_sel, drain_req,
    output stall, flush_id, issue_hold, issue_fire, drain_ack, gpr_pending, pred_pending, hazard_cnt
  );
endinterface

// File: rtl/sm_scoreboard_ctrl.sv
// sm_scoreboard_ctrl: GPR/predicate scoreboard, RAW/WAW bubble insertion, lane-busy stall and drain handshake (clk, rst, sb bus)
module sm_scoreboard_ctrl #(
  parameter int NUM_SP = 4,
  parameter int BYPASS_WB = 1,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst,
  sm_scoreboard_ctrl_if.slave sb
);
  typedef enum logic [1:0] {IDLE, DRAIN, DONE} state_t;
  state_t r_state;
  logic [15:0] r_gpr_pending, w_gpr_eff, w_clr_g, w_set_g;
  logic [3:0] r_pred_pending, w_pred_eff, w_clr_p, w_set_p;
  logic [CNT_W-1:0] r_hazard_cnt;
  logic r_drain_ack, w_stall, w_raw, w_waw, w_hazard, w_block, w_fire, w_flush, w_hold, w_hz_bubble;
  always_comb begin
    w_stall = |sb.core_busy;
    w_clr_g = (sb.wb_valid & sb.wb_rf_we & ~w_stall) ? 16'd1 << sb.wb_rD_addr : 16'd0;
    w_clr_p = (sb.wb_valid & sb.wb_pred_we & ~w_stall) ? 4'd1 << sb.wb_pred_wr_sel : 4'd0;
    w_gpr_eff = (BYPASS_WB != 0) ? r_gpr_pending & ~w_clr_g : r_gpr_pending;
    w_pred_eff = (BYPASS_WB != 0) ? r_pred_pending & ~w_clr_p : r_pred_pending;
    w_raw = (sb.id_src_use[0] & w_gpr_eff[sb.id_src_addr[3:0]])
          | (sb.id_src_use[1] & w_gpr_eff[sb.id_src_addr[7:4]])
          | (sb.id_src_use[2] & w_gpr_eff[sb.id_src_addr[11:8]])
          | (sb.id_pred_use & w_pred_eff[sb.id_pred_rd_sel]);
    w_waw = (sb.id_rf_we & w_gpr_eff[sb.id_rD_addr]) | (sb.id_pred_we & w_pred_eff[sb.id_pred_wr_sel]);
    w_hazard = sb.id_valid & (w_raw | w_waw);
    w_block = w_hazard | (r_state != IDLE);
    w_fire = sb.id_valid & ~w_block & ~sb.branch_flush & ~w_stall;
    w_flush = ~w_stall & (sb.branch_flush | (sb.id_valid & w_block));
    w_hold = w_stall | (sb.id_valid & w_block & ~sb.branch_flush);
    w_hz_bubble = w_hazard & ~sb.branch_flush & ~w_stall;
    w_set_g = (w_fire & sb.id_rf_we) ? 16'd1 << sb.id_rD_addr : 16'd0;
    w_set_p = (w_fire & sb.id_pred_we) ? 4'd1 << sb.id_pred_wr_sel : 4'd0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_gpr_pending <= '0;
      r_pred_pending <= '0;
      r_hazard_cnt <= '0;
      r_drain_ack <= 1'b0;
    end else begin
      if (!w_stall) begin
        r_gpr_pending <= (r_gpr_pending & ~w_clr_g) | w_set_g;
        r_pred_pending <= (r_pred_pending & ~w_clr_p) | w_set_p;
      end
      if (w_hz_bubble && !(&r_hazard_cnt)) r_hazard_cnt <= r_hazard_cnt + CNT_W'(1);
      case (r_state)
        IDLE: if (sb.drain_req) r_state <= DRAIN;
        DRAIN: begin
          if (!sb.drain_req) r_state <= IDLE;
          else if (r_gpr_pending == '0 && r_pred_pending == '0 && !w_stall) begin
            r_state <= DONE;
            r_drain_ack <= 1'b1;
          end
        end
        DONE: if (!sb.drain_req) begin
          r_state <= IDLE;
          r_drain_ack <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign sb.stall = w_stall;
  assign sb.flush_id = w_flush;
  assign sb.issue_hold = w_hold;
  assign sb.issue_fire = w_fire;
  assign sb.drain_ack = r_drain_ack;
  assign sb.gpr_pending = r_gpr_pending;
  assign sb.pred_pending = r_pred_pending;
  assign sb.hazard_cnt = r_hazard_cnt;
endmodule

// File: tb/tb_sm_scoreboard_ctrl.sv
// tb_sm_scoreboard_ctrl: vector table plus hand-written drain, saturation and reset sequences
module tb_sm_scoreboard_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  sm_scoreboard_ctrl_if #(.NUM_SP(4), .CNT_W(16)) sb ();
  sm_scoreboard_ctrl #(.NUM_SP(4), .BYPASS_WB(1), .CNT_W(16)) dut (.clk(clk), .rst(rst), .sb(sb));
  typedef struct {
    logic v, rf_we; logic [3:0] rd; logic p_we; logic [1:0] pws;
    logic [11:0] src; logic [2:0] use_m; logic puse; logic [1:0] prs; logic bf;
    logic wbv, wbrf; logic [3:0] wbrd; logic wbp; logic [1:0] wbps; logic [3:0] busy;
    logic e_stall, e_flush, e_hold, e_fire; logic [15:0] e_gpr; logic [3:0] e_pred; logic [15:0] e_hcnt;
  } vec_t;
  vec_t vecs [24];
  vec_t exp_q [$];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask
  task automatic clear_in();
    sb.core_busy = '0; sb.id_valid = 0; sb.id_rf_we = 0; sb.id_rD_addr = '0; sb.id_pred_we = 0;
    sb.id_pred_wr_sel = '0; sb.id_src_addr = '0; sb.id_src_use = '0; sb.id_pred_use = 0;
    sb.id_pred_rd_sel = '0; sb.branch_flush = 0; sb.wb_valid = 0; sb.wb_rf_we = 0; sb.wb_rD_addr = '0;
    sb.wb_pred_we = 0; sb.wb_pred_wr_sel = '0;
  endtask
  task automatic next();
    @(posedge clk);
    #1 clear_in();
  endtask
  task automatic settle();
    @(negedge clk);
  endtask
  task automatic issue(input logic [3:0] rd);
    sb.id_valid = 1; sb.id_rf_we = 1; sb.id_rD_addr = rd;
  endtask
  task automatic wb(input logic [3:0] rd);
    sb.wb_valid = 1; sb.wb_rf_we = 1; sb.wb_rD_addr = rd;
  endtask
  task automatic drive(input vec_t x);
    sb.id_valid = x.v; sb.id_rf_we = x.rf_we; sb.id_rD_addr = x.rd; sb.id_pred_we = x.p_we;
    sb.id_pred_wr_sel = x.pws; sb.id_src_addr = x.src; sb.id_src_use = x.use_m; sb.id_pred_use = x.puse;
    sb.id_pred_rd_sel = x.prs; sb.branch_flush = x.bf; sb.wb_valid = x.wbv; sb.wb_rf_we = x.wbrf;
    sb.wb_rD_addr = x.wbrd; sb.wb_pred_we = x.wbp; sb.wb_pred_wr_sel = x.wbps; sb.core_busy = x.busy;
  endtask
  initial begin
    vec_t e;
    vecs[0]  = '{1,1,3,0,0,12'h000,3'b000,0,0,0, 0,0,0,0,0, 4'h0, 0,0,0,1, 16'h0000,4'h0,16'd0};
    vecs[1]  = '{1,1,4,0,0,12'h003,3'b001,0,0,0, 0,0,0,0,0, 4'h0, 0,1,1,0, 16'h0008,4'h0,16'd0};
    vecs[2]  = '{1,1,4,0,0,12'h003,3'b001,0,0,0, 0,0,0,0,0, 4'h0, 0,1,1,0, 16'h0008,4'h0,16'd1};
    vecs[3]  = '{1,1,4,0,0,12'h003,3'b001,0,0,0, 1,1,3,0,0, 4'h0, 0,0,0,1, 16'h0008,4'h0,16'd2};
    vecs[4]  = '{0,0,0,0,0,12'h000,3'b000,0,0,0, 0,0,0,0,0, 4'h0, 0,0,0,0, 16'h0010,4'h0,16'd2};
    vecs[5]  = '{0,0,0,0,0,12'h000,3'b000,0,0,0, 1,1,4,0,0, 4'h0, 0,0,0,0, 16'h0010,4'h0,16'd2};
    vecs[6]  = '{0,0,0,0,0,12'h000,3'b000,0,0,0, 0,0,0,0,0, 4'h0, 0,0,0,0, 16'h0000,4'h0,16'd2};
    vecs[7]  = '{1,1,5,0,0,12'h000,3'b000,0,0,0, 0,0,0,0,0, 4'h0, 0,0,0,1, 16'h0000,4'h0,16'd2};
    vecs[8]  = '{0,0,0,0,0,12'h000,3'b000,0,0,0, 1,1,5,0,0, 4'h4, 1,0,1,0, 16'h0020,4'h0,16'd2};
    vecs[9]  = '{0,0,0,0,0,12'h000,3'b000,0,0,0, 1,1,5,0,0, 4'h4, 1,0,1,0, 16'h0020,4'h0,16'd2};
    vecs[10] = '{0,0,0,0,0,12'h000,3'b000,0,0,0, 1,1,5,0,0, 4'h0, 0,0,0,0, 16'h0020,4'h0,16'd2};
    vecs[11] = '{0,0,0,0,0,12'h000,3'b000,0,0,0, 0,0,0,0,0, 4'h0, 0,0,0,0, 16'h0000,4'h0,16'd2};
    vecs[12] = '{1,0,0,1,1,12'h000,3'b000,0,0,0, 0,0,0,0,0, 4'h0, 0,0,0,1, 16'h0000,4'h0,16'd2};
    vecs[13] = '{1,0,0,0,0,12'h000,3'b000,1,1,0, 0,0,0,0,0, 4'h0, 0,1,1,0, 16'h0000,4'h2,16'd2};
    vecs[14] = '{1,0,0,0,0,12'h000,3'b000,1,1,0, 1,0,0,1,1, 4'h0, 0,0,0,1, 16'h0000,4'h2,16'd3};
    vecs[15] = '{0,0,0,0,0,12'h000,3'b000,0,0,0, 0,0,0,0,0, 4'h0, 0,0,0,0, 16'h0000,4'h0,16'd3};
    vecs[16] = '{1,1,7,0,0,12'h000,3'b000,0,0,0, 0,0,0,0,0, 4'h0, 0,0,0,1, 16'h0000,4'h0,16'd3};
    vecs[17] = '{1,0,0,0,0,12'h070,3'b010,0,0,1, 0,0,0,0,0, 4'h0, 0,1,0,0, 16'h0080,4'h0,16'd3};
    vecs[18] = '{0,0,0,0,0,12'h000,3'b000,0,0,0, 0,0,0,0,0, 4'h0, 0,0,0,0, 16'h0080,4'h0,16'd3};
    vecs[19] = '{1,1,7,0,0,12'h000,3'b000,0,0,0, 0,0,0,0,0, 4'h0, 0,1,1,0, 16'h0080,4'h0,16'd3};
    vecs[20] = '{0,0,0,0,0,12'h000,3'b000,0,0,0, 1,1,7,0,0, 4'h0, 0,0,0,0, 16'h0080,4'h0,16'd4};
    vecs[21] = '{0,0,0,0,0,12'h000,3'b000,0,0,0, 0,0,0,0,0, 4'h0, 0,0,0,0, 16'h0000,4'h0,16'd4};
    vecs[22] = '{0,0,0,0,0,12'h000,3'b000,0,0,0, 1,1,9,0,0, 4'h0, 0,0,0,0, 16'h0000,4'h0,16'd4};
    vecs[23] = '{0,0,0,0,0,12'h000,3'b000,0,0,0, 0,0,0,0,0, 4'h0, 0,0,0,0, 16'h0000,4'h0,16'd4};
    clear_in();
    sb.drain_req = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    settle();
    chk("rst_gpr", 32'(sb.gpr_pending), 0);
    chk("rst_pred", 32'(sb.pred_pending), 0);
    chk("rst_hcnt", 32'(sb.hazard_cnt), 0);
    chk("rst_ack", 32'(sb.drain_ack), 0);
    chk("rst_stall", 32'(sb.stall), 0);
    for (int i = 0; i < 24; i++) begin
      next();
      drive(vecs[i]);
      exp_q.push_back(vecs[i]);
      settle();
      e = exp_q.pop_front();
      chk($sformatf("v%0d_stall", i), 32'(sb.stall), 32'(e.e_stall));
      chk($sformatf("v%0d_flush", i), 32'(sb.flush_id), 32'(e.e_flush));
      chk($sformatf("v%0d_hold", i), 32'(sb.issue_hold), 32'(e.e_hold));
      chk($sformatf("v%0d_fire", i), 32'(sb.issue_fire), 32'(e.e_fire));
      chk($sformatf("v%0d_gpr", i), 32'(sb.gpr_pending), 32'(e.e_gpr));
      chk($sformatf("v%0d_pred", i), 32'(sb.pred_pending), 32'(e.e_pred));
      chk($sformatf("v%0d_hcnt", i), 32'(sb.hazard_cnt), 32'(e.e_hcnt));
    end
    next(); issue(5); settle(); chk("dr_fire5", 32'(sb.issue_fire), 1);
    next(); issue(6); settle(); chk("dr_fire6", 32'(sb.issue_fire), 1);
    next(); sb.drain_req = 1; settle(); chk("dr_ack0", 32'(sb.drain_ack), 0);
    next(); issue(8); settle();
    chk("dr_flush", 32'(sb.flush_id), 1);
    chk("dr_hold", 32'(sb.issue_hold), 1);
    chk("dr_nofire", 32'(sb.issue_fire), 0);
    next(); wb(5); settle(); chk("dr_gpr56", 32'(sb.gpr_pending), 32'h60); chk("dr_ack1", 32'(sb.drain_ack), 0);
    next(); wb(6); settle(); chk("dr_gpr6", 32'(sb.gpr_pending), 32'h40);
    next(); settle(); chk("dr_gpr0", 32'(sb.gpr_pending), 0); chk("dr_ack2", 32'(sb.drain_ack), 0);
    next(); settle(); chk("dr_ack_up", 32'(sb.drain_ack), 1);
    next(); sb.drain_req = 0; settle(); chk("dr_ack_hold", 32'(sb.drain_ack), 1);
    next(); issue(8); settle(); chk("dr_ack_down", 32'(sb.drain_ack), 0); chk("dr_refire", 32'(sb.issue_fire), 1);
    next(); wb(8); settle();
    next(); settle(); chk("dr_clean", 32'(sb.gpr_pending), 0); chk("dr_hcnt", 32'(sb.hazard_cnt), 4);
    next(); issue(9); settle(); chk("dd_fire9", 32'(sb.issue_fire), 1);
    next(); sb.drain_req = 1; settle();
    next(); issue(10); settle(); chk("dd_blocked", 32'(sb.flush_id), 1);
    next(); sb.drain_req = 0; issue(10); settle(); chk("dd_still_blk", 32'(sb.issue_fire), 0);
    next(); issue(10); settle(); chk("dd_fire10", 32'(sb.issue_fire), 1); chk("dd_noack", 32'(sb.drain_ack), 0);
    next(); wb(9); settle();
    next(); wb(10); settle();
    next(); settle(); chk("dd_clean", 32'(sb.gpr_pending), 0); chk("dd_hcnt", 32'(sb.hazard_cnt), 4);
    next(); issue(2); settle(); chk("sat_fire2", 32'(sb.issue_fire), 1);
    for (int j = 1; j <= 65540; j++) begin
      next();
      sb.id_valid = 1; sb.id_src_addr = 12'h002; sb.id_src_use = 3'b001;
      settle();
      if (j == 65001) chk("sat_mid", 32'(sb.hazard_cnt), 65004);
    end
    chk("sat_full", 32'(sb.hazard_cnt), 32'hFFFF);
    chk("sat_flush", 32'(sb.flush_id), 1);
    next(); sb.drain_req = 1; settle();
    next(); settle(); chk("rd_pend", 32'(sb.gpr_pending), 32'h4); chk("rd_noack", 32'(sb.drain_ack), 0);
    next(); rst = 1; settle();
    next(); rst = 0; sb.drain_req = 0; sb.id_valid = 1; sb.id_src_addr = 12'h002; sb.id_src_use = 3'b001; settle();
    chk("rd_gpr", 32'(sb.gpr_pending), 0);
    chk("rd_pred", 32'(sb.pred_pending), 0);
    chk("rd_hcnt", 32'(sb.hazard_cnt), 0);
    chk("rd_ack", 32'(sb.drain_ack), 0);
    chk("rd_fire", 32'(sb.issue_fire), 1);
    next(); wb(2); settle();
    next(); settle(); chk("rd_late_wb", 32'(sb.gpr_pending), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
